regfile_write_sched: RTL and testbench
======================================

Name: regfile_write_sched

Overview:
- Schedules the single GPR write port of the ID-stage register file between two requesters: the pipeline writeback (WB) stage, and a multi-cycle multiply/divide unit (MDU) that returns GPR results out of band.
- WB has priority. MDU results wait in a small FIFO and drain into idle write-port cycles.
- A starvation guard briefly holds WB so the FIFO always drains.
- The block exports a pending-register mask so the hazard unit can stall decode on in-flight MDU destinations.

Parameters:
- DEPTH, 2, MDU result FIFO entries (power of two, ≥2).
- STARVE_LIMIT, 4, consecutive denied cycles of a non-empty FIFO before WB is held (≥1).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- wb_RegWrite  in  1  WB stage requests a write.
- wb_write_register  in  5  WB destination.
- wb_write_data  in  32  WB data.
- mdu_valid  in  1  MDU offers a result.
- mdu_ready  out  1  FIFO can accept; equals !full (combinational).
- mdu_register  in  5  MDU destination.
- mdu_data  in  32  MDU data.
- wb_hold  out  1  registered; pipeline must freeze WB for this cycle and re-present its request next cycle.
- RegWrite  out  1  registered write enable to the register file.
- write_register  out  5  registered write address.
- write_data  out  32  registered write data.
- pending_mask  out  32  bit r set while any FIFO entry, or the output register, targets r with MDU origin; bit 0 always 0.
- squash_err  out  1  one-cycle pulse when a WB write squashes a FIFO entry.

Behaviour:
- Reset (async):
  - FIFO empty, starvation counter 0, state NORMAL.
  - RegWrite, write_register, write_data, wb_hold, squash_err all 0; pending_mask 0; mdu_ready 1.
- Latency:
  - The write port is driven one cycle after the granted request: request in cycle N gives RegWrite high in cycle N+1. The register file commits at the end of N+1.
  - A MDU result accepted in cycle N can appear on the port no earlier than N+1.
- Request qualification:
  - A WB request is wb_RegWrite && wb_write_register != 0.
  - An MDU handshake is mdu_valid && mdu_ready.
  - An MDU handshake with mdu_register == 0 completes but is not enqueued.
- Same-cycle enqueue/dequeue:
  - Enqueue and dequeue may happen in the same cycle.
  - When full, simultaneous dequeue does not raise mdu_ready in that cycle, because ready is derived from the current occupancy.
  - An MDU offer arriving while the FIFO is empty can never bypass the FIFO; it is enqueued first.
- State NORMAL:
  - If there is a WB request: grant WB, and the port output takes the WB address/data.
  - Else if the FIFO is non-empty: grant the FIFO head and pop it.
  - Else: RegWrite is 0 next cycle, and address/data hold their previous values.
  - Starvation counter:
    - Increments each cycle the FIFO is non-empty and WB is granted.
    - Clears when the FIFO is granted or the FIFO is empty.
  - When the counter reaches STARVE_LIMIT, go to FORCE and assert wb_hold in the next cycle.
- State FORCE (exactly one cycle, wb_hold = 1):
  - Grant the FIFO head unconditionally.
  - The WB request is ignored (not lost: the pipeline re-presents it).
  - Counter clears; return to NORMAL.
- Conflict:
  - When a WB request targets r and FIFO entries target r, those entries are invalidated: they are skipped at dequeue without using a port cycle, and squash_err pulses for one cycle.
  - The hazard unit prevents this case via pending_mask; it is an error indication only.
  - In FORCE, the ignored WB request squashes nothing.
- pending_mask:
  - OR of the one-hot destinations of valid FIFO entries, plus write_register when RegWrite is high and the current output came from the FIFO.
  - Updated in the same cycle as the state change (computed from registered state).
- Reset mid-operation: all queued MDU results are discarded; the MDU must reissue them. A write in progress on the port is dropped.
- RegWrite is never asserted with write_register == 0.

Test Plan:
- WB-only write (wb_RegWrite=1, reg 8, data 0x1234 in cycle N):
  - Required: RegWrite=1, write_register=8, write_data=0x1234 in N+1.
  - Required: pending_mask stays 0.
- MDU write to idle port (mdu_valid, reg 5, 0xDEAD in N; no WB):
  - Required: pending_mask[5]=1 from N+1.
  - Required: port writes 5/0xDEAD in N+2; pending_mask[5] clears in N+3.
- FIFO full:
  - Stimulus: WB writes every cycle; MDU offers regs 3, 4, 6.
  - Required: regs 3 and 4 are accepted, then mdu_ready=0 for 6.
  - Required: after the FIFO drains, reg 6 is accepted.
- Starvation (STARVE_LIMIT=4):
  - Stimulus: FIFO holds one entry while WB requests continuously.
  - Required: wb_hold=1 on the 5th cycle, and the FIFO entry is written the following cycle.
  - Required: the WB request presented during hold is written one cycle later.
- Register 0:
  - Stimulus: WB to reg 0, then MDU to reg 0.
  - Required: RegWrite stays 0, the MDU handshake completes, and the FIFO stays empty.
- Conflict and reset:
  - Stimulus: FIFO entry reg 7; WB writes reg 7.
  - Required: squash_err pulses, and reg 7 is written only once with the WB data.
  - Stimulus: rst asserted mid-drain.
  - Required: all outputs 0 immediately and mdu_ready=1.

Source files
------------

// File: rtl/regfile_write_sched.sv
// Arbitrates the single GPR write port between WB (priority) and a queued MDU result
// stream; one-cycle registered port, starvation guard holds WB to drain the queue.
module regfile_write_sched #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_RegWrite,
  input  logic [4:0]  wb_write_register,
  input  logic [31:0] wb_write_data,
  input  logic        mdu_valid,
  output logic        mdu_ready,
  input  logic [4:0]  mdu_register,
  input  logic [31:0] mdu_data,
  output logic        wb_hold,
  output logic        RegWrite,
  output logic [4:0]  write_register,
  output logic [31:0] write_data,
  output logic [31:0] pending_mask,
  output logic        squash_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [0:0] ST_NORMAL = 1'b0;
  localparam logic [0:0] ST_FORCE  = 1'b1;

  logic [4:0]       fifo_reg [DEPTH];
  logic [31:0]      fifo_dat [DEPTH];
  logic [DEPTH-1:0] fifo_vld;
  logic [AW-1:0]    rd_ptr, wr_ptr;
  logic [AW:0]      count;
  logic [0:0]       state;
  logic [CW-1:0]    starve_cnt, starve_nxt;
  logic             from_fifo;

  logic             full, nonempty, has_valid, head_vld;
  logic             wb_req, enq, deq, skip, grant_wb, grant_fifo, in_force;
  logic [DEPTH-1:0] squash_vec;

  assign full      = (count == (AW+1)'(DEPTH));
  assign mdu_ready = !full;
  assign nonempty  = (count != '0);
  assign has_valid = |fifo_vld;
  assign head_vld  = nonempty && fifo_vld[rd_ptr];
  assign in_force  = (state == ST_FORCE);
  assign wb_hold   = in_force;

  assign wb_req     = wb_RegWrite && (wb_write_register != 5'd0);
  assign enq        = mdu_valid && mdu_ready && (mdu_register != 5'd0);
  assign grant_wb   = wb_req && !in_force;
  assign grant_fifo = head_vld && !grant_wb;
  // Squashed entries are retired from the head without occupying the write port.
  assign skip       = nonempty && !fifo_vld[rd_ptr];
  assign deq        = grant_fifo || skip;

  always_comb begin
    for (int i = 0; i < DEPTH; i++)
      squash_vec[i] = grant_wb && fifo_vld[i] && (fifo_reg[i] == wb_write_register);
  end

  always_comb begin
    starve_nxt = starve_cnt;
    if (in_force || !has_valid || grant_fifo)
      starve_nxt = '0;
    else if (grant_wb)
      starve_nxt = starve_cnt + CW'(1);
  end

  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < DEPTH; i++)
      if (fifo_vld[i]) pending_mask[fifo_reg[i]] = 1'b1;
    if (RegWrite && from_fifo) pending_mask[write_register] = 1'b1;
    pending_mask[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      fifo_reg[wr_ptr] <= mdu_register;
      fifo_dat[wr_ptr] <= mdu_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_vld   <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      state      <= ST_NORMAL;
      starve_cnt <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (enq && (wr_ptr == AW'(i)))
          fifo_vld[i] <= 1'b1;
        else if (deq && (rd_ptr == AW'(i)))
          fifo_vld[i] <= 1'b0;
        else if (squash_vec[i])
          fifo_vld[i] <= 1'b0;
      end
      if (enq) wr_ptr <= wr_ptr + AW'(1);
      if (deq) rd_ptr <= rd_ptr + AW'(1);
      count      <= count + {{AW{1'b0}}, enq} - {{AW{1'b0}}, deq};
      starve_cnt <= starve_nxt;
      state      <= (starve_nxt == CW'(STARVE_LIMIT)) ? ST_FORCE : ST_NORMAL;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      RegWrite       <= 1'b0;
      write_register <= '0;
      write_data     <= '0;
      from_fifo      <= 1'b0;
      squash_err     <= 1'b0;
    end else begin
      squash_err <= |squash_vec;
      if (grant_wb) begin
        RegWrite       <= 1'b1;
        write_register <= wb_write_register;
        write_data     <= wb_write_data;
        from_fifo      <= 1'b0;
      end else if (grant_fifo) begin
        RegWrite       <= 1'b1;
        write_register <= fifo_reg[rd_ptr];
        write_data     <= fifo_dat[rd_ptr];
        from_fifo      <= 1'b1;
      end else begin
        RegWrite  <= 1'b0;
        from_fifo <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_sched.sv
// Directed checks of regfile_write_sched: reset, WB/MDU writes, full FIFO, starvation, r0, squash, reset.
module tb_regfile_write_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_RegWrite;
  logic [4:0]  wb_write_register;
  logic [31:0] wb_write_data;
  logic        mdu_valid;
  logic        mdu_ready;
  logic [4:0]  mdu_register;
  logic [31:0] mdu_data;
  logic        wb_hold;
  logic        RegWrite;
  logic [4:0]  write_register;
  logic [31:0] write_data;
  logic [31:0] pending_mask;
  logic        squash_err;

  int tests = 0;
  int fails = 0;

  regfile_write_sched #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .wb_RegWrite(wb_RegWrite), .wb_write_register(wb_write_register), .wb_write_data(wb_write_data),
    .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_register(mdu_register), .mdu_data(mdu_data),
    .wb_hold(wb_hold), .RegWrite(RegWrite), .write_register(write_register), .write_data(write_data),
    .pending_mask(pending_mask), .squash_err(squash_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic port(input string tag, input logic we, input logic [4:0] r, input logic [31:0] d);
    chk({tag, ".we"}, {31'd0, RegWrite}, {31'd0, we});
    if (we) begin
      chk({tag, ".reg"}, {27'd0, write_register}, {27'd0, r});
      chk({tag, ".dat"}, write_data, d);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb(input logic en, input logic [4:0] r, input logic [31:0] d);
    wb_RegWrite = en; wb_write_register = r; wb_write_data = d;
  endtask

  task automatic mdu(input logic en, input logic [4:0] r, input logic [31:0] d);
    mdu_valid = en; mdu_register = r; mdu_data = d;
  endtask

  initial begin
    rst = 1'b1;
    wb(0, 0, 0);
    mdu(0, 0, 0);
    tick(); tick();
    chk("rst.we", {31'd0, RegWrite}, 32'd0);
    chk("rst.reg", {27'd0, write_register}, 32'd0);
    chk("rst.dat", write_data, 32'd0);
    chk("rst.hold", {31'd0, wb_hold}, 32'd0);
    chk("rst.sq", {31'd0, squash_err}, 32'd0);
    chk("rst.mask", pending_mask, 32'd0);
    chk("rst.rdy", {31'd0, mdu_ready}, 32'd1);
    rst = 1'b0;
    tick();

    // WB-only write
    wb(1, 8, 32'h1234);
    tick();
    port("wb", 1, 8, 32'h1234);
    chk("wb.mask", pending_mask, 32'd0);
    wb(0, 0, 0);
    tick();
    chk("wb.idle_we", {31'd0, RegWrite}, 32'd0);
    chk("wb.hold_reg", {27'd0, write_register}, 32'd8);

    // MDU write to idle port
    mdu(1, 5, 32'hDEAD);
    chk("mdu.rdy", {31'd0, mdu_ready}, 32'd1);
    tick();
    mdu(0, 0, 0);
    chk("mdu.n1_mask", pending_mask, 32'h20);
    chk("mdu.n1_we", {31'd0, RegWrite}, 32'd0);
    tick();
    port("mdu.n2", 1, 5, 32'hDEAD);
    chk("mdu.n2_mask", pending_mask, 32'h20);
    tick();
    chk("mdu.n3_mask", pending_mask, 32'd0);
    chk("mdu.n3_we", {31'd0, RegWrite}, 32'd0);

    // Register 0: WB ignored, MDU handshakes but never enqueues
    wb(1, 0, 32'h5555);
    tick();
    chk("r0.wb_we", {31'd0, RegWrite}, 32'd0);
    wb(0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      mdu(1, 0, 32'hBAD0 + i);
      chk("r0.rdy", {31'd0, mdu_ready}, 32'd1);
      tick();
      chk("r0.mask", pending_mask, 32'd0);
      chk("r0.we", {31'd0, RegWrite}, 32'd0);
    end
    mdu(0, 0, 0);
    tick();
    chk("r0.drain_we", {31'd0, RegWrite}, 32'd0);

    // Starvation: one queued entry vs continuous WB
    mdu(1, 9, 32'h99);
    wb(1, 10, 32'hA0);
    tick();
    mdu(0, 0, 0);
    chk("st.mask", pending_mask, 32'h200);
    for (int k = 1; k <= 4; k++) begin
      chk("st.hold_lo", {31'd0, wb_hold}, 32'd0);
      port("st.wb", 1, 5'(9 + k), 32'hA0 + k - 1);
      wb(1, 5'(10 + k), 32'hA0 + k);
      tick();
    end
    chk("st.hold_hi", {31'd0, wb_hold}, 32'd1);
    port("st.c5", 1, 14, 32'hA4);
    wb(1, 15, 32'hA5);
    tick();
    chk("st.c6_hold", {31'd0, wb_hold}, 32'd0);
    port("st.c6_fifo", 1, 9, 32'h99);
    chk("st.c6_mask", pending_mask, 32'h200);
    tick();
    port("st.c7_wb", 1, 15, 32'hA5);
    chk("st.c7_mask", pending_mask, 32'd0);
    wb(0, 0, 0);
    tick();
    chk("st.idle", {31'd0, RegWrite}, 32'd0);

    // FIFO full under continuous WB
    wb(1, 20, 32'h20); mdu(1, 3, 32'h33);
    chk("full.f0_rdy", {31'd0, mdu_ready}, 32'd1);
    tick();
    wb(1, 21, 32'h21); mdu(1, 4, 32'h44);
    chk("full.f1_rdy", {31'd0, mdu_ready}, 32'd1);
    tick();
    for (int k = 2; k <= 4; k++) begin
      wb(1, 5'(20 + k), 32'h20 + k); mdu(1, 6, 32'h66);
      chk("full.rdy_lo", {31'd0, mdu_ready}, 32'd0);
      chk("full.hold_lo", {31'd0, wb_hold}, 32'd0);
      tick();
    end
    chk("full.f5_hold", {31'd0, wb_hold}, 32'd1);
    chk("full.f5_rdy", {31'd0, mdu_ready}, 32'd0);
    wb(1, 25, 32'h25);
    tick();
    port("full.f6", 1, 3, 32'h33);
    chk("full.f6_rdy", {31'd0, mdu_ready}, 32'd1);
    chk("full.f6_mask", pending_mask, 32'h18);
    tick();
    wb(0, 0, 0); mdu(0, 0, 0);
    port("full.f7", 1, 25, 32'h25);
    chk("full.f7_mask", pending_mask, 32'h50);
    tick();
    port("full.f8", 1, 4, 32'h44);
    chk("full.f8_mask", pending_mask, 32'h50);
    tick();
    port("full.f9", 1, 6, 32'h66);
    chk("full.f9_mask", pending_mask, 32'h40);
    tick();
    chk("full.f10_we", {31'd0, RegWrite}, 32'd0);
    chk("full.f10_mask", pending_mask, 32'd0);

    // Conflict: WB to a register with a queued MDU result
    mdu(1, 7, 32'h77); wb(1, 30, 32'h30);
    tick();
    mdu(0, 0, 0); wb(1, 7, 32'h700);
    chk("sq.mask", pending_mask, 32'h80);
    chk("sq.pre", {31'd0, squash_err}, 32'd0);
    tick();
    wb(0, 0, 0);
    port("sq.wb", 1, 7, 32'h700);
    chk("sq.pulse", {31'd0, squash_err}, 32'd1);
    chk("sq.mask_clr", pending_mask, 32'd0);
    tick();
    chk("sq.pulse_end", {31'd0, squash_err}, 32'd0);
    chk("sq.no_write", {31'd0, RegWrite}, 32'd0);
    tick();
    chk("sq.no_write2", {31'd0, RegWrite}, 32'd0);

    // Reset mid-drain
    mdu(1, 11, 32'hB1); wb(1, 16, 32'h40);
    tick();
    mdu(1, 12, 32'hB2); wb(1, 17, 32'h41);
    tick();
    mdu(0, 0, 0); wb(0, 0, 0);
    chk("rm.full", {31'd0, mdu_ready}, 32'd0);
    tick();
    port("rm.drain", 1, 11, 32'hB1);
    rst = 1'b1;
    #1;
    chk("rm.we", {31'd0, RegWrite}, 32'd0);
    chk("rm.reg", {27'd0, write_register}, 32'd0);
    chk("rm.dat", write_data, 32'd0);
    chk("rm.mask", pending_mask, 32'd0);
    chk("rm.rdy", {31'd0, mdu_ready}, 32'd1);
    chk("rm.hold", {31'd0, wb_hold}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("rm.post_we", {31'd0, RegWrite}, 32'd0);
    tick();
    chk("rm.post_we2", {31'd0, RegWrite}, 32'd0);
    chk("rm.post_mask", pending_mask, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
